uart_bus_loader: RTL and testbench
==================================

Name: uart_bus_loader

Overview:
- Bus initiator that talks to the same 32-bit peripheral/memory bus (rd, wr, addr, wdata, rdata) as the UART MMIO peripheral.
- Receives command bytes from a host over a byte-level receive interface and issues single-word bus reads and writes.
- Returns response bytes through a byte-level transmit handshake.
- Used for boot loading and debug; while a command is in progress, busy holds the CPU off the bus.

Parameters:
- TIMEOUT_CYCLES, 32'd1_000_000: maximum sysclk cycles between bytes of one command before the command is abandoned.
- CMD_WR, 8'h57: write command byte ('W').
- CMD_RD, 8'h52: read command byte ('R').
- ACK_BYTE, 8'h4B: write acknowledge byte ('K').
- ERR_BYTE, 8'h3F: unknown-command reply byte ('?').

Ports:
- sysclk  in  1  single clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  held high until accepted.
- tx_ready  in  1  transmitter can accept; a transfer occurs when tx_valid & tx_ready.
- rd  out  1  bus read strobe, one cycle.
- wr  out  1  bus write strobe, one cycle.
- addr  out  32  bus address.
- wdata  out  32  bus write data.
- rdata  in  32  bus read data, combinational from addr/rd in the same cycle.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values: state IDLE; rd=0, wr=0, tx_valid=0, busy=0; tx_data=0, addr=0, wdata=0; byte counter and timeout counter 0.
- IDLE, rx_valid asserted:
  - CMD_WR -> ADDR with op=write, byte count=0.
  - CMD_RD -> ADDR with op=read.
  - Any other byte -> REPLY with a single byte ERR_BYTE.
- ADDR: each rx_valid shifts a byte into addr from the LSB side, so addr ends up as {addr[23:0], rx_data} and the first byte received is the MSB. After the 4th byte: op=write -> DATA; op=read -> READ.
- DATA: same shifting into wdata. After the 4th byte -> WRITE.
- WRITE: wr=1 for exactly one cycle, with addr and wdata stable. Next state REPLY with a single byte ACK_BYTE.
- READ: rd=1 for exactly one cycle; rdata is captured into a 32-bit response register in that same cycle. Next state REPLY with 4 bytes, MSB first.
- REPLY:
  - tx_valid=1, tx_data = current byte.
  - On tx_valid & tx_ready, advance to the next byte on the following cycle. tx_valid stays high between bytes; there is no bubble requirement.
  - After the last byte is accepted: tx_valid=0 and state -> IDLE.
- Latency:
  - Last write data byte -> wr: 1 cycle. wr -> tx_valid: 1 cycle.
  - Last address byte of a read -> rd: 1 cycle. rd -> tx_valid with the MSB: 1 cycle.
- Timeout:
  - The counter clears on every rx_valid and counts in ADDR and DATA only.
  - On reaching TIMEOUT_CYCLES-1, go to IDLE; no reply and no bus strobe.
- rx_valid in WRITE, READ or REPLY is ignored and dropped. Commands are not pipelined.
- rx_valid in the same cycle as a timeout: the timeout wins and the byte is dropped.
- Asynchronous reset at any point, including mid-REPLY: tx_valid, rd and wr drop immediately, and no partial transaction completes.
- Only one of rd and wr is ever high, and neither is high outside READ or WRITE.
- Counters:
  - Byte counter is 2 bits and wraps 3->0 at each phase transition.
  - Timeout counter is 32 bits and saturates at the terminal count.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, ADDR, DATA, WRITE, READ, REPLY, 3 bits);
  - the CMD_WR, CMD_RD, ACK_BYTE and ERR_BYTE constants;
  - the bus width constant of 32.
- One sub-module, uart_loader_timeout: loadable inter-byte counter with clear and enable inputs and a terminal-count output.
- The state machine, shift registers and reply sequencer stay in the top module.

Test Plan:
- Write command: rx bytes 57 40 00 00 18 00 00 00 41 -> one-cycle wr with addr=32'h40000018 and wdata=32'h00000041, then a single tx byte 4B; busy falls after the tx handshake.
- Read command: rx bytes 52 40 00 00 20, bench rdata=32'h0000001B -> one-cycle rd with addr=32'h40000020, then tx bytes 00 00 00 1B in order; hold tx_ready low for 3 cycles mid-sequence and check tx_data is stable and no byte is lost.
- Unknown byte: rx byte 41 -> tx byte 3F, no rd or wr, return to IDLE.
- Timeout: rx bytes 57 12, then silence for TIMEOUT_CYCLES -> busy=0 with no strobe; a following 52 + 4 address bytes is decoded correctly.
- Reset mid-reply: assert reset during the 2nd read reply byte -> tx_valid=0 and busy=0 immediately; after release, a write command completes normally.
- Stray byte: rx_valid during REPLY -> the byte is ignored, and the reply sequence and the next command are unaffected.

Source files
------------

// File: rtl/uart_bus_loader_pkg.sv
// Shared encodings and constants for the UART-driven bus loader.
// Covers the state encoding, the host command and reply bytes, and the bus width.
package uart_bus_loader_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [7:0] CMD_WR   = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD   = 8'h52;  // 'R'
  localparam logic [7:0] ACK_BYTE = 8'h4B;  // 'K'
  localparam logic [7:0] ERR_BYTE = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4,
    ST_REPLY = 3'd5
  } state_t;

endpackage

// File: rtl/uart_loader_timeout.sv
// Inter-byte timeout counter. Clear has priority over enable, and the count
// saturates at the terminal value TIMEOUT_CYCLES-1, where tc is asserted.
module uart_loader_timeout #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [31:0] TERMINAL = TIMEOUT_CYCLES - 32'd1;

  logic [31:0] count;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      count <= 32'd0;
    end else if (clear) begin
      count <= 32'd0;
    end else if (enable && (count != TERMINAL)) begin
      count <= count + 32'd1;
    end
  end

  assign tc = (count == TERMINAL);

endmodule

// File: rtl/uart_bus_loader.sv
// Host-byte command interpreter that issues single-word bus reads and writes
// and streams the reply bytes back through a valid/ready transmit port.
module uart_bus_loader
  import uart_bus_loader_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy
);

  // tx handshake: a byte moves when tx_valid & tx_ready are both high at a
  // rising sysclk edge; tx_valid then stays high until the last byte moves.
  state_t          state;
  state_t          state_nxt;
  logic            op_wr;
  logic [1:0]      byte_cnt;
  logic [1:0]      reply_last;
  logic [BUS_W-1:0] resp;
  logic            to_en;
  logic            to_clear;
  logic            to_tc;

  assign to_en    = (state == ST_ADDR) || (state == ST_DATA);
  assign to_clear = rx_valid || !to_en;

  uart_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .sysclk(sysclk),
    .reset (reset),
    .clear (to_clear),
    .enable(to_en),
    .tc    (to_tc)
  );

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    wr        = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) state_nxt = ST_ADDR;
          else                                           state_nxt = ST_REPLY;
        end
      end
      ST_ADDR: begin
        // A timeout in the same cycle as a byte wins; the byte is dropped.
        if (to_tc)                              state_nxt = ST_IDLE;
        else if (rx_valid && byte_cnt == 2'd3)  state_nxt = op_wr ? ST_DATA : ST_READ;
      end
      ST_DATA: begin
        if (to_tc)                              state_nxt = ST_IDLE;
        else if (rx_valid && byte_cnt == 2'd3)  state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        wr        = 1'b1;
        state_nxt = ST_REPLY;
      end
      ST_READ: begin
        rd        = 1'b1;
        state_nxt = ST_REPLY;
      end
      ST_REPLY: begin
        tx_valid = 1'b1;
        tx_data  = resp[BUS_W-1 -: 8];
        if (tx_ready && (byte_cnt == reply_last)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // resp doubles as the reply shifter: the byte on tx_data is always its top byte.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      op_wr      <= 1'b0;
      byte_cnt   <= 2'd0;
      reply_last <= 2'd0;
      addr       <= '0;
      wdata      <= '0;
      resp       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            byte_cnt <= 2'd0;
            if (rx_data == CMD_WR) begin
              op_wr <= 1'b1;
            end else if (rx_data == CMD_RD) begin
              op_wr <= 1'b0;
            end else begin
              resp       <= {ERR_BYTE, 24'h000000};
              reply_last <= 2'd0;
            end
          end
        end
        ST_ADDR: begin
          if (to_tc) begin
            byte_cnt <= 2'd0;
          end else if (rx_valid) begin
            addr     <= {addr[BUS_W-9:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        ST_DATA: begin
          if (to_tc) begin
            byte_cnt <= 2'd0;
          end else if (rx_valid) begin
            wdata    <= {wdata[BUS_W-9:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        ST_WRITE: begin
          resp       <= {ACK_BYTE, 24'h000000};
          reply_last <= 2'd0;
          byte_cnt   <= 2'd0;
        end
        ST_READ: begin
          resp       <= rdata;
          reply_last <= 2'd3;
          byte_cnt   <= 2'd0;
        end
        ST_REPLY: begin
          if (tx_ready) begin
            resp     <= {resp[BUS_W-9:0], 8'h00};
            byte_cnt <= (byte_cnt == reply_last) ? 2'd0 : (byte_cnt + 2'd1);
          end
        end
        default: begin
          byte_cnt <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_loader.sv
// Directed bench for uart_bus_loader: write, read with tx stall, unknown byte,
// inter-byte timeout, reset mid-reply and a stray byte during a reply.
module tb_uart_bus_loader;

  localparam logic [31:0] TO_CYC = 32'd16;

  logic        sysclk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [31:0] wr_addr_seen;
  logic [31:0] wr_data_seen;
  logic [31:0] rd_addr_seen;
  logic [7:0]  exp_q[$];

  uart_bus_loader #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .sysclk  (sysclk),
    .reset   (reset),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy)
  );

  // Bus model: one known word, every other address reads back its complement.
  assign rdata = (addr == 32'h40000020) ? 32'h0000001B : ~addr;

  // clock / reset
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge sysclk) begin
    if (reset) begin
      if (rd && wr) check_eq("rd_wr_excl", 32'(rd && wr), 32'd0);
      if (wr) begin
        wr_cnt++;
        wr_addr_seen = addr;
        wr_data_seen = wdata;
      end
      if (rd) begin
        rd_cnt++;
        rd_addr_seen = addr;
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check_eq("tx_extra", 32'(exp_q.size()), 32'd1);
        else                   check_eq("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(posedge sysclk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge sysclk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      @(posedge sysclk); #1;
      n++;
    end
    check_eq(tag, {31'h0, busy}, 32'd0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    #23;
    check_eq("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
    check_eq("rst_busy", {31'h0, busy}, 32'd0);
    check_eq("rst_rdwr", {30'h0, rd, wr}, 32'd0);
    check_eq("rst_tx_data", {24'h0, tx_data}, 32'd0);
    check_eq("rst_addr", addr, 32'd0);
    check_eq("rst_wdata", wdata, 32'd0);
    reset = 1'b1;
    cycles(2);

    // Write command
    exp_q.push_back(8'h4B);
    send_byte(8'h57);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h18);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h41);
    check_eq("wr_lat", {31'h0, wr}, 32'd1);
    check_eq("wr_addr", addr, 32'h40000018);
    check_eq("wr_wdata", wdata, 32'h00000041);
    cycles(1);
    check_eq("wr_one_cycle", {31'h0, wr}, 32'd0);
    check_eq("wr_tx_valid", {31'h0, tx_valid}, 32'd1);
    check_eq("wr_tx_data", {24'h0, tx_data}, 32'h4B);
    wait_idle("wr_idle");
    check_eq("wr_count", 32'(wr_cnt), 32'd1);
    check_eq("wr_q_empty", 32'(exp_q.size()), 32'd0);

    // Read command with a 3-cycle tx stall on the last byte
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h1B);
    send_byte(8'h52);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    check_eq("rd_lat", {31'h0, rd}, 32'd1);
    check_eq("rd_addr", addr, 32'h40000020);
    cycles(1);
    check_eq("rd_one_cycle", {31'h0, rd}, 32'd0);
    check_eq("rd_tx_valid", {31'h0, tx_valid}, 32'd1);
    check_eq("rd_tx_msb", {24'h0, tx_data}, 32'h00);
    cycles(3);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_data", {24'h0, tx_data}, 32'h1B);
      check_eq("stall_valid", {31'h0, tx_valid}, 32'd1);
      cycles(1);
    end
    tx_ready = 1'b1;
    wait_idle("rd_idle");
    check_eq("rd_count", 32'(rd_cnt), 32'd1);
    check_eq("rd_q_empty", 32'(exp_q.size()), 32'd0);

    // Unknown command byte
    exp_q.push_back(8'h3F);
    send_byte(8'h41);
    check_eq("unk_valid", {31'h0, tx_valid}, 32'd1);
    wait_idle("unk_idle");
    check_eq("unk_strobes", 32'(rd_cnt + wr_cnt), 32'd2);
    check_eq("unk_q_empty", 32'(exp_q.size()), 32'd0);

    // Inter-byte timeout, then a clean read
    send_byte(8'h57);
    send_byte(8'h12);
    cycles(5);
    check_eq("to_busy_mid", {31'h0, busy}, 32'd1);
    cycles(15);
    check_eq("to_busy_end", {31'h0, busy}, 32'd0);
    check_eq("to_no_strobe", 32'(rd_cnt + wr_cnt), 32'd2);
    exp_q.push_back(8'hED); exp_q.push_back(8'hCB);
    exp_q.push_back(8'hA9); exp_q.push_back(8'h87);
    send_byte(8'h52);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    check_eq("to_rd_addr", addr, 32'h12345678);
    wait_idle("to_rd_idle");
    check_eq("to_rd_addr_seen", rd_addr_seen, 32'h12345678);
    check_eq("to_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset while the second read reply byte is on offer
    exp_q.push_back(8'h00);
    send_byte(8'h52);
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    cycles(2);
    #2 reset = 1'b0;
    #1;
    check_eq("rr_tx_valid", {31'h0, tx_valid}, 32'd0);
    check_eq("rr_busy", {31'h0, busy}, 32'd0);
    check_eq("rr_rdwr", {30'h0, rd, wr}, 32'd0);
    cycles(2);
    reset = 1'b1;
    check_eq("rr_q_empty", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(8'h4B);
    send_byte(8'h57);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_idle("rr_wr_idle");
    check_eq("rr_wr_addr", wr_addr_seen, 32'hAABBCCDD);
    check_eq("rr_wr_data", wr_data_seen, 32'h11223344);
    check_eq("rr_wr_q_empty", 32'(exp_q.size()), 32'd0);

    // Stray byte during a reply is dropped
    exp_q.push_back(8'h4B);
    tx_ready = 1'b0;
    send_byte(8'h57);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
    send_byte(8'h52);
    check_eq("stray_busy", {31'h0, busy}, 32'd1);
    check_eq("stray_tx_data", {24'h0, tx_data}, 32'h4B);
    tx_ready = 1'b1;
    wait_idle("stray_idle");
    check_eq("stray_wr_data", wr_data_seen, 32'h00000007);
    exp_q.push_back(8'h3F);
    send_byte(8'h00);
    wait_idle("stray_next_idle");
    check_eq("stray_q_empty", 32'(exp_q.size()), 32'd0);
    check_eq("final_strobes", 32'(rd_cnt + wr_cnt), 32'd6);

    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
